// File: rtl/main_fsm_pkg.sv
// Shared controller package: main FSM state encodings, Op class constants and
// the control-word layout decoded from each state.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam int FUNCT_I = 5;
  localparam int FUNCT_L = 0;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_flopr.sv
// Codebase resettable flop: synchronous active-high reset to zero.
module flopr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle processor main control FSM (Moore): state held in flopr,
// next-state and control decode are purely combinational on the state.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State
);

  logic [3:0] state, nxt;
  ctrl_t      ctrl;

  // Only I and L matter to the main FSM; the rest of Funct feeds ALU decode.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  flopr #(.WIDTH(4)) u_state (
    .clk  (clk),
    .reset(reset),
    .d    (nxt),
    .q    (state)
  );

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (Op)
          OP_DP:   nxt = Funct[FUNCT_I] ? EXECUTEI : EXECUTER;
          OP_MEM:  nxt = MEMADR;
          OP_BR:   nxt = BRANCH;
          default: nxt = UNKNOWN;
        endcase
      end
      MEMADR:   nxt = Funct[FUNCT_L] ? MEMRD : MEMWR;
      MEMRD:    nxt = MEMWB;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      default:  nxt = FETCH;  // terminal states, UNKNOWN and encodings 11-15
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.irwrite   = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = 2'b10;
        ctrl.resultsrc = 2'b10;
      end
      DECODE: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = 2'b10;
        ctrl.resultsrc = 2'b10;
      end
      MEMADR:   ctrl.alusrcb = 2'b01;
      MEMRD:    ctrl.adrsrc  = 1'b1;
      MEMWB: begin
        ctrl.resultsrc = 2'b01;
        ctrl.regw      = 1'b1;
      end
      MEMWR: begin
        ctrl.adrsrc = 1'b1;
        ctrl.memw   = 1'b1;
      end
      EXECUTER: ctrl.aluop = 1'b1;
      EXECUTEI: begin
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = 1'b1;
      end
      ALUWB:    ctrl.regw = 1'b1;
      BRANCH: begin
        ctrl.alusrcb   = 2'b01;
        ctrl.resultsrc = 2'b10;
        ctrl.branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite   = ctrl.irwrite;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign NextPC    = ctrl.nextpc;
  assign RegW      = ctrl.regw;
  assign MemW      = ctrl.memw;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.aluop;
  assign State     = state;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed instructions plus randomized
// Op/Funct run against a path/latency reference model.
module tb_main_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXER = 6, S_EXEI = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_UNK = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;

  main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .State(State)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected control word per state:
  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}
  logic [11:0] out_tab [0:10];

  int q[$];
  int exp_cur;
  int cnt;
  int exp_len;
  int n_regw_alu, n_memw;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] obs_word();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};
  endfunction

  task automatic check_now();
    chk("state", {12'd0, State}, exp_cur[15:0]);
    chk("outputs", {4'd0, obs_word()}, {4'd0, out_tab[exp_cur]});
    chk("one_hot_writes", 16'($countones({RegW, MemW, Branch}) <= 1), 16'd1);
  endtask

  task automatic enter_fetch();
    exp_cur = S_FETCH;
    q.delete();
    q.push_back(S_DECODE);
    cnt = 1;
  endtask

  // One clock: apply inputs, advance the model, then check after the edge.
  task automatic cyc(input logic [1:0] op, input logic [5:0] fn, input logic rs);
    int nxt;
    Op = op; Funct = fn; reset = rs;
    nxt = S_FETCH;
    if (!rs) begin
      if (exp_cur == S_DECODE) begin
        case (op)
          2'b00: begin q.push_back(fn[5] ? S_EXEI : S_EXER); q.push_back(S_ALUWB); exp_len = 4; end
          2'b01: q.push_back(S_MEMADR);
          2'b10: begin q.push_back(S_BRANCH); exp_len = 3; end
          default: begin q.push_back(S_UNK); exp_len = 3; end
        endcase
      end else if (exp_cur == S_MEMADR) begin
        if (fn[0]) begin q.push_back(S_MEMRD); q.push_back(S_MEMWB); exp_len = 5; end
        else begin q.push_back(S_MEMWR); exp_len = 4; end
      end
      if (q.size() == 0) begin
        chk("latency", cnt[15:0], exp_len[15:0]);
        nxt = S_FETCH;
      end else begin
        nxt = q.pop_front();
      end
    end
    @(posedge clk);
    #1;
    if (nxt == S_FETCH) enter_fetch();
    else begin exp_cur = nxt; cnt++; end
    check_now();
  endtask

  // Run one instruction from FETCH to its completion with steady inputs.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn);
    int guard = 0;
    do begin
      cyc(op, fn, 1'b0);
      guard++;
    end while (exp_cur != S_FETCH && guard < 10);
  endtask

  initial begin
    out_tab[S_FETCH]  = {1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    out_tab[S_DECODE] = {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_tab[S_MEMADR] = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_tab[S_MEMRD]  = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_tab[S_MEMWB]  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    out_tab[S_MEMWR]  = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_tab[S_EXER]   = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_tab[S_EXEI]   = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_tab[S_ALUWB]  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    out_tab[S_BRANCH] = {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_tab[S_UNK]    = 12'd0;
    exp_len = 0;
    n_regw_alu = 0;
    n_memw = 0;

    // Reset with junk inputs, held for two edges.
    reset = 1'b1; Op = 2'b11; Funct = 6'h3f;
    @(posedge clk); #1;
    cyc(2'b01, 6'h01, 1'b1);
    chk("reset_irwrite", {15'd0, IRWrite}, 16'd1);
    chk("reset_nextpc",  {15'd0, NextPC},  16'd1);

    // Data-processing register; count RegW pulses over the instruction.
    begin
      int guard = 0;
      do begin
        cyc(2'b00, 6'h00, 1'b0);
        if (RegW) n_regw_alu++;
        guard++;
      end while (exp_cur != S_FETCH && guard < 10);
    end
    chk("dp_regw_pulses", n_regw_alu[15:0], 16'd1);

    run_instr(2'b01, 6'h01);  // load
    // Store: count MemW cycles.
    begin
      int guard = 0;
      do begin
        cyc(2'b01, 6'h00, 1'b0);
        if (MemW) n_memw++;
        guard++;
      end while (exp_cur != S_FETCH && guard < 10);
    end
    chk("store_memw_pulses", n_memw[15:0], 16'd1);
    run_instr(2'b10, 6'h15);  // branch
    run_instr(2'b11, 6'h2a);  // undefined

    // Immediate DP, with Op toggled while in EXECUTEI.
    cyc(2'b00, 6'h20, 1'b0);  // FETCH -> DECODE
    cyc(2'b00, 6'h20, 1'b0);  // DECODE -> EXECUTEI
    chk("in_executei", {12'd0, State}, S_EXEI[15:0]);
    cyc(2'b10, 6'h01, 1'b0);  // toggled inputs, still -> ALUWB
    cyc(2'b01, 6'h01, 1'b0);  // ALUWB -> FETCH

    // Reset asserted in MEMWR aborts the store.
    cyc(2'b01, 6'h00, 1'b0);
    cyc(2'b01, 6'h00, 1'b0);
    cyc(2'b01, 6'h00, 1'b0);
    chk("in_memwr", {12'd0, State}, S_MEMWR[15:0]);
    cyc(2'b01, 6'h00, 1'b1);
    chk("abort_memw", {15'd0, MemW}, 16'd0);
    chk("abort_state", {12'd0, State}, S_FETCH[15:0]);

    // Randomized inputs every cycle with occasional reset.
    for (int i = 0; i < 10000; i++) begin
      cyc(2'($urandom), 6'($urandom), ($urandom_range(0, 199) == 0));
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameters: none; widths fixed by the multicycle datapath.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  input  6  instruction Funct field; bit 5 = I (immediate operand), bit 0 = L (load).
REQ-006 IRWrite  output  1  instruction register load enable.
REQ-007 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 ALUSrcA  output  1  ALU A select: 0 = register A, 1 = PC.
REQ-009 ALUSrcB  output  2  ALU B select: 00 = register, 01 = ExtImm, 10 = constant 4.
REQ-010 ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-011 NextPC  output  1  PC update request to the conditional logic.
REQ-012 RegW  output  1  register write request, gated downstream by the condition check.
REQ-013 MemW  output  1  memory write request, gated downstream by the condition check.
REQ-014 Branch  output  1  branch PC update request.
REQ-015 ALUOp  output  1  1 = decode ALU control from Funct; 0 = ALU add.
REQ-016 State  output  4  current state encoding, for debug and verification.

Function
REQ-017 Moore machine; all outputs SHALL be a function of the current state only, with no input-to-output combinational path.
REQ-018 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN, encoded 0 to 10 in that order; encodings 11-15 SHALL behave as UNKNOWN.
REQ-019 Transitions:
- FETCH -> DECODE.
- DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
REQ-020 Transitions:
- MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD -> MEMWB.
- EXECUTER, EXECUTEI -> ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN -> FETCH.
REQ-021 FETCH outputs: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
REQ-022 DECODE outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
REQ-023 MEMADR outputs: ALUSrcA=0, ALUSrcB=01.
REQ-024 MEMRD outputs: AdrSrc=1, ResultSrc=00.
REQ-025 MEMWB outputs: ResultSrc=01, RegW=1.
REQ-026 MEMWR outputs: AdrSrc=1, ResultSrc=00, MemW=1.
REQ-027 EXECUTER outputs: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
REQ-028 EXECUTEI outputs: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
REQ-029 ALUWB outputs: ResultSrc=00, RegW=1.
REQ-030 BRANCH outputs: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-031 Unlisted outputs SHALL be 0; UNKNOWN SHALL drive all outputs 0.
REQ-032 Instruction latency SHALL be: load 5 cycles, store 4, data-processing 4, branch 3, undefined 3.
REQ-033 Op and Funct SHALL be sampled only in DECODE and MEMADR and ignored in all other states.
REQ-034 At most one of RegW, MemW, Branch SHALL be 1 in any cycle.

Reset
REQ-035 With reset=1 at a rising clk edge, State SHALL become FETCH regardless of the current state or inputs.
REQ-036 After reset, outputs SHALL equal the FETCH values (IRWrite=1, NextPC=1); reset asserted mid-instruction SHALL abort that instruction with no further RegW or MemW pulse.

Structure
REQ-037 The state encodings and the Op class constants SHALL reside in the shared controller package.
REQ-038 The state register SHALL be one instance of the codebase 4-bit resettable flop (flopr); next-state and output decode SHALL be combinational logic in main_fsm.

Verification
REQ-039 Reset, then Op=00, Funct=000000 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegW=1 only in ALUWB.
REQ-040 Op=01, Funct=000001 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; AdrSrc=1 in MEMRD; ResultSrc=01 and RegW=1 in MEMWB.
REQ-041 Op=01, Funct=000000 -> MEMADR then MEMWR with MemW=1 for exactly one cycle, then FETCH.
REQ-042 Op=10 -> BRANCH with Branch=1, ALUSrcB=01, then FETCH; Op=11 -> UNKNOWN with all outputs 0, then FETCH.
REQ-043 Op=00, Funct=100000 -> EXECUTEI with ALUSrcB=01 and ALUOp=1; Op toggled in EXECUTEI -> no effect on the state sequence.
REQ-044 reset asserted in MEMWR -> next cycle FETCH, MemW=0; randomized Op/Funct for 10k cycles -> REQ-034 holds in every cycle.
